aoi_pattern_checker: RTL
========================

Name: aoi_pattern_checker

Overview:
- Self-test sequencer for the 4-input AND-OR-INVERT gate block (inputs a,b,c,d; outputs e=a&b, f=c&d, g=~((a&b)|(c&d))).
- Drives all 16 input combinations into the gate and samples its three outputs back.
- Compares the sampled outputs against an internal golden model, then reports the error count, the first failing vector and a pass flag.
- Sits beside the gate on the lab board: `vec_out` goes to the gate inputs, the gate outputs return on `dut_e`/`dut_f`/`dut_g`.

Parameters:
- SETTLE_CYCLES, 2, clocks each vector is held before sampling; legal range 1..15.
- ERR_W, 5, width of the error counter; the counter saturates at 2^ERR_W-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep
- vec_out  output  4  drive to gate: [3]=a, [2]=b, [1]=c, [0]=d
- dut_e  input  1  gate output e
- dut_f  input  1  gate output f
- dut_g  input  1  gate output g
- busy  output  1  high while a sweep is running
- done  output  1  high in DONE state; results valid
- pass  output  1  done && err_cnt==0
- err_cnt  output  ERR_W  number of mismatching vectors
- first_fail_vec  output  4  first vector that mismatched
- first_fail_valid  output  1  first_fail_vec holds a real failure

Behaviour:
- Reset (async, rst=1): state IDLE; vec_out=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0, settle counter=0. Reset mid-sweep aborts the sweep immediately; no partial result is retained.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: on start=1, clear err_cnt/first_fail_*, set vec_out=0, busy=1, go DRIVE.
- DRIVE: vec_out stable; settle counter counts 0..SETTLE_CYCLES-1, then go SAMPLE. DRIVE occupies exactly SETTLE_CYCLES clocks per vector.
- SAMPLE (1 clock):
  - Expected values: exp_e=a&b, exp_f=c&d, exp_g=~(exp_e|exp_f), computed from vec_out.
  - Mismatch = any of dut_e/f/g differs from its expected bit.
  - On mismatch: err_cnt+1, saturating at 2^ERR_W-1. If first_fail_valid=0, latch first_fail_vec=vec_out and set first_fail_valid=1.
  - If vec_out==15: go DONE; vec_out holds 15. Otherwise vec_out+1 and go DRIVE.
- Sweep length: 16*(SETTLE_CYCLES+1) clocks from the start-accept edge to DONE entry (48 at default).
- DONE: busy=0, done=1, pass=(err_cnt==0). Results are held until the next start. On start=1, behave as IDLE-accept: clear results, done=0, pass=0, go DRIVE.
- start is ignored while busy=1.
- All outputs are registered; dut_* inputs are sampled only on the SAMPLE edge.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes straight to DONE with err_cnt=1; vec_out holds the failing vector; pass=0.
- Undefined: the sweep always runs all 16 vectors, as described under Behaviour.

Test Plan:
- Correct gate model on dut_*, start pulse -> busy for 48 clocks; done=1, pass=1, err_cnt=0, first_fail_valid=0, vec_out=15.
- dut_g stuck at 0 -> err_cnt=9 (vectors with ab!=11 and cd!=11); first_fail_vec=0, first_fail_valid=1, pass=0.
- dut_e and dut_f swapped -> err_cnt=6; first_fail_vec=3 (0011).
- STOP_ON_FAIL_EN defined, dut_g stuck at 0 -> done after 3 clocks; err_cnt=1, first_fail_vec=0, vec_out=0.
- Extra start pulse at clock 10 of a sweep -> ignored, sweep still finishes at clock 48. Second start from DONE -> results clear and a new 48-clock sweep runs.
- rst asserted at clock 20 of a sweep -> all outputs 0 immediately, state IDLE. A fresh start then completes normally with pass=1.

Source files
------------

// File: rtl/aoi_pattern_checker.sv
// Self-test sequencer for the AND-OR-INVERT gate block: sweeps all 16 input vectors and grades the responses.
// Optional build macro STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module aoi_pattern_checker #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [3:0]       vec_out,
   input  logic             dut_e,
   input  logic             dut_f,
   input  logic             dut_g,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       first_fail_vec,
   output logic             first_fail_valid
);

   localparam int unsigned CNT_W = 4;
   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] settle_cnt, settle_cnt_nxt;
   logic [3:0]       vec_nxt, ffv_nxt;
   logic             busy_nxt, done_nxt, pass_nxt, ffvld_nxt;
   logic [ERR_W-1:0] err_nxt;
   logic             exp_e, exp_f, exp_g, mismatch;

   // Golden gate response for the vector currently driven
   assign exp_e    = vec_out[3] & vec_out[2];
   assign exp_f    = vec_out[1] & vec_out[0];
   assign exp_g    = ~(exp_e | exp_f);
   assign mismatch = (dut_e != exp_e) || (dut_f != exp_f) || (dut_g != exp_g);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start) state_nxt = DRIVE;
         DRIVE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
         SAMPLE: begin
`ifdef STOP_ON_FAIL_EN
            if (mismatch || vec_out == 4'hF) state_nxt = DONE;
            else                             state_nxt = DRIVE;
`else
            if (vec_out == 4'hF) state_nxt = DONE;
            else                 state_nxt = DRIVE;
`endif
         end
         DONE:   if (start) state_nxt = DRIVE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs and settle counter
   always_comb begin
      vec_nxt        = vec_out;
      settle_cnt_nxt = settle_cnt;
      busy_nxt       = busy;
      done_nxt       = done;
      pass_nxt       = pass;
      err_nxt        = err_cnt;
      ffv_nxt        = first_fail_vec;
      ffvld_nxt      = first_fail_valid;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               vec_nxt        = 4'h0;
               settle_cnt_nxt = '0;
               busy_nxt       = 1'b1;
               done_nxt       = 1'b0;
               pass_nxt       = 1'b0;
               err_nxt        = '0;
               ffv_nxt        = 4'h0;
               ffvld_nxt      = 1'b0;
            end
         end
         DRIVE: begin
            if (settle_cnt == SETTLE_LAST) settle_cnt_nxt = '0;
            else                           settle_cnt_nxt = settle_cnt + CNT_W'(1);
         end
         SAMPLE: begin
            if (mismatch) begin
               if (err_cnt != ERR_MAX) err_nxt = err_cnt + ERR_W'(1);
               if (!first_fail_valid) begin
                  ffv_nxt   = vec_out;
                  ffvld_nxt = 1'b1;
               end
            end
            if (state_nxt == DONE) begin
               busy_nxt = 1'b0;
               done_nxt = 1'b1;
               pass_nxt = (err_nxt == '0);
            end else begin
               vec_nxt = vec_out + 4'h1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_out          <= 4'h0;
         settle_cnt       <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_cnt          <= '0;
         first_fail_vec   <= 4'h0;
         first_fail_valid <= 1'b0;
      end else begin
         vec_out          <= vec_nxt;
         settle_cnt       <= settle_cnt_nxt;
         busy             <= busy_nxt;
         done             <= done_nxt;
         pass             <= pass_nxt;
         err_cnt          <= err_nxt;
         first_fail_vec   <= ffv_nxt;
         first_fail_valid <= ffvld_nxt;
      end
   end

endmodule
